// File: rtl/dp_ram_port_master.sv
// Initiator-side controller for one port of a dual-port RAM: clears the RAM after reset, then
// turns a valid/ready request stream into RAM port cycles and returns read data.
module dp_ram_port_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [2:0] {StInit, StIdle, StRdWait, StRdCap, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  init_done_q, init_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StInit: begin
        // Top counter bit set means every word has been cleared.
        if (!cnt_q[ADDR_WIDTH]) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = cnt_q[ADDR_WIDTH-1:0];
          ram_din_d  = '0;
          cnt_d      = cnt_q + 1'b1;
        end else begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIdle: begin
        if (req_valid) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            ram_wr_d  = 1'b1;
            ram_din_d = req_wdata;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        rsp_rdata_d = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule
